// File: rtl/core_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// core_clk_rst_seq
//
// Power-up/power-down sequencer for a single clock/reset domain. Software
// holds up_req_i high to request the domain running. On the way up the block
// applies the PLL dividers, waits for lock with a timeout, enables the clock,
// and releases reset after a settle period. On the way down it asserts reset
// first and gates the clock after a hold period.
//
// Parameters
//   LOCK_TIMEOUT  cycles to wait for PLL lock before flagging an error (>=1)
//   CLK_SETTLE    cycles the clock runs with reset held before release (>=1)
//   RST_HOLD      cycles reset is held with the clock running before gating (>=1)
//
// Ports
//   clk_i           clock
//   arst_ni         asynchronous active-low reset
//   up_req_i        level request: 1 = domain running, 0 = domain off
//   pll_ref_div_i   requested PLL reference divider (captured when leaving OFF)
//   pll_fb_div_i    requested PLL feedback divider (captured when leaving OFF)
//   pll_locked_i    PLL lock indication, asynchronous to clk_i
//   pll_ref_div_o   reference divider applied to the PLL
//   pll_fb_div_o    feedback divider applied to the PLL
//   clk_en_o        domain clock enable
//   rst_no          domain reset, active-low
//   busy_o          a sequence step is in progress
//   running_o       domain is up
//   err_o           lock timeout or lock loss
//   state_o         current sequencer state for status readback
// -----------------------------------------------------------------------------
module core_clk_rst_seq #(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned CLK_SETTLE   = 16,
  parameter int unsigned RST_HOLD     = 8
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        up_req_i,
  input  logic [3:0]  pll_ref_div_i,
  input  logic [11:0] pll_fb_div_i,
  input  logic        pll_locked_i,
  output logic [3:0]  pll_ref_div_o,
  output logic [11:0] pll_fb_div_o,
  output logic        clk_en_o,
  output logic        rst_no,
  output logic        busy_o,
  output logic        running_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  localparam int unsigned MAX_AB = (LOCK_TIMEOUT > CLK_SETTLE) ? LOCK_TIMEOUT : CLK_SETTLE;
  localparam int unsigned MAX_P  = (MAX_AB > RST_HOLD) ? MAX_AB : RST_HOLD;
  localparam int          CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_LOCK_WAIT  = 3'd1,
    ST_CLK_SETTLE = 3'd2,
    ST_RUN        = 3'd3,
    ST_RST_HOLD   = 3'd4,
    ST_ERR        = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ref_div_q, ref_div_d;
  logic [11:0]        fb_div_q, fb_div_d;
  logic [1:0]         lock_sync_q;
  logic               lk;
  logic               clk_en_q, clk_en_d;
  logic               rst_n_q, rst_n_d;
  logic               busy_q, busy_d;
  logic               running_q, running_d;
  logic               err_q, err_d;

  // NOTE: pll_locked_i comes from another clock domain; only the second flop
  // of this chain may feed logic, the first is allowed to go metastable.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
    end
  end

  assign lk = lock_sync_q[1];

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_div_d = ref_div_q;
    fb_div_d  = fb_div_q;

    case (state_q)
      ST_OFF: begin
        if (up_req_i) begin
          state_d   = ST_LOCK_WAIT;
          ref_div_d = pll_ref_div_i;
          fb_div_d  = pll_fb_div_i;
        end
      end
      ST_LOCK_WAIT: begin
        if (!up_req_i)               state_d = ST_OFF;
        else if (lk)                 state_d = ST_CLK_SETTLE;
        else if (cnt_q == LOCK_LAST) state_d = ST_ERR;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_CLK_SETTLE: begin
        // Losing lock while the clock already runs is an error even if the
        // request drops on the same cycle.
        if (!lk)                       state_d = ST_ERR;
        else if (!up_req_i)            state_d = ST_OFF;
        else if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (!lk)            state_d = ST_ERR;
        else if (!up_req_i) state_d = ST_RST_HOLD;
      end
      ST_RST_HOLD: begin
        // Shutdown always runs to completion; a new request restarts from OFF.
        if (cnt_q == HOLD_LAST) state_d = ST_OFF;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_ERR: begin
        if (!up_req_i) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state and registered, so they switch on
  // the same edge as the state itself.
  always_comb begin
    clk_en_d  = (state_d == ST_CLK_SETTLE) || (state_d == ST_RUN) || (state_d == ST_RST_HOLD);
    rst_n_d   = (state_d == ST_RUN);
    busy_d    = (state_d == ST_LOCK_WAIT) || (state_d == ST_CLK_SETTLE) || (state_d == ST_RST_HOLD);
    running_d = (state_d == ST_RUN);
    err_d     = (state_d == ST_ERR);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      ref_div_q <= '0;
      fb_div_q  <= '0;
      clk_en_q  <= 1'b0;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_div_q <= ref_div_d;
      fb_div_q  <= fb_div_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      running_q <= running_d;
      err_q     <= err_d;
    end
  end

  assign pll_ref_div_o = ref_div_q;
  assign pll_fb_div_o  = fb_div_q;
  assign clk_en_o      = clk_en_q;
  assign rst_no        = rst_n_q;
  assign busy_o        = busy_q;
  assign running_o     = running_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule
